// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: opcodes, unary selects, instruction field
// positions, register file geometry and the control FSM state encoding.
package alu_seq_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_UNARY = 2'b01;
  localparam logic [1:0] OP_BEQZ  = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  localparam logic [1:0] UN_PASS = 2'b00;
  localparam logic [1:0] UN_INC  = 2'b01;
  localparam logic [1:0] UN_SUB2 = 2'b10;
  localparam logic [1:0] UN_DEC  = 2'b11;

  localparam int OP_HI = 7;
  localparam int OP_LO = 6;
  localparam int RS_HI = 5;
  localparam int RS_LO = 4;
  localparam int RT_HI = 3;
  localparam int RT_LO = 2;
  localparam int FN_HI = 1;
  localparam int FN_LO = 0;

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXEC} state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x8 register file: combinational RS/RT/debug reads, one synchronous write port,
// synchronous clear on rst.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        rs_addr,
  input  logic [1:0]        rt_addr,
  input  logic [1:0]        dbg_sel,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] dbg_data
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] data_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
        end else if (wr_en && wr_addr == 2'(gi)) begin
          data_reg <= wr_data;
        end
      end
      assign regs[gi] = data_reg;
    end
  endgenerate

  assign rs_data  = regs[rs_addr];
  assign rt_data  = regs[rt_addr];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: FETCH/DECODE/EXEC control unit driving a shared 8-bit ALU and a 4x8
// register file. Define ALU_SEQ_WATCHDOG_EN to compile in the MAX_STEPS run watchdog.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MAX_STEPS = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic       alu_src,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  output logic [1:0] alu_in3,
  input  logic [7:0] alu_out,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data
);

  state_t     state_reg, state_next;
  logic [7:0] pc_reg, pc_next;
  logic [7:0] ir_reg, ir_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       err_reg, err_next;

  logic [1:0] op, rs, rt, fn;
  logic [7:0] rs_data, rt_data;
  logic [7:0] br_target;
  logic       exec, wr_en, abort;

  assign op        = ir_reg[OP_HI:OP_LO];
  assign rs        = ir_reg[RS_HI:RS_LO];
  assign rt        = ir_reg[RT_HI:RT_LO];
  assign fn        = ir_reg[FN_HI:FN_LO];
  assign exec      = (state_reg == EXEC);
  assign wr_en     = exec && (op == OP_ADD || op == OP_UNARY);
  // {RT,FN} doubles as a signed 4-bit branch offset relative to PC+1.
  assign br_target = pc_reg + 8'd1 + {{4{rt[1]}}, rt, fn};

  alu_seq_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (rs),
    .rt_addr  (rt),
    .dbg_sel  (dbg_sel),
    .wr_en    (wr_en),
    .wr_addr  (rt),
    .wr_data  (alu_out),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_data (dbg_data)
  );

  always_comb begin
    alu_src = 1'b0;
    alu_in1 = '0;
    alu_in2 = '0;
    alu_in3 = UN_PASS;
    if (wr_en) begin
      alu_in1 = rs_data;
      alu_in2 = rt_data;
      if (op == OP_UNARY) begin
        alu_src = 1'b1;
        alu_in3 = fn;
      end
    end
  end

`ifdef ALU_SEQ_WATCHDOG_EN
  logic [7:0] step_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      step_reg <= '0;
    end else if (exec) begin
      step_reg <= step_reg + 8'd1;
    end
  end

  // Fires on the EXEC that brings the count to MAX_STEPS; that instruction still writes back.
  assign abort = exec && (op != OP_HALT) && ((step_reg + 8'd1) == MAX_STEPS[7:0]);
`else
  logic unused_max_steps;
  assign unused_max_steps = ^MAX_STEPS;
  assign abort            = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          pc_next    = '0;
          busy_next  = 1'b1;
        end
      end
      FETCH:  state_next = DECODE;
      DECODE: begin
        ir_next    = imem_data;
        state_next = EXEC;
      end
      EXEC: begin
        state_next = FETCH;
        pc_next    = pc_reg + 8'd1;
        if (op == OP_BEQZ && rs_data == 8'd0) begin
          pc_next = br_target;
        end
        if (op == OP_HALT) begin
          state_next = IDLE;
          pc_next    = pc_reg;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else if (abort) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign imem_addr = pc_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: ISA-level model feeds a scoreboard of expected
// run results that are popped and compared when DONE is seen.
module tb_alu_sequencer;

  localparam int WD_STEPS = 10;

  typedef struct {
    int              edges;
    logic            err;
    logic [3:0][7:0] regs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, busy, done, err;
  logic [7:0] imem_addr, imem_data, alu_in1, alu_in2, alu_out, dbg_data;
  logic       alu_src;
  logic [1:0] alu_in3, dbg_sel;

  logic [7:0] mem [256];
  logic [7:0] m_regs [4];
  exp_t       sb [$];
  logic [7:0] r0_trace [$];
  bit         alu_seen;
  logic [7:0] cap_in1;
  logic [1:0] cap_in3;
  int         checks = 0;
  int         errors = 0;
  int         wrap_cnt = 0;
  logic [7:0] prev_addr = 8'd0;

  alu_sequencer #(.MAX_STEPS(WD_STEPS)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_src(alu_src), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_in3(alu_in3),
    .alu_out(alu_out), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];

  always_comb begin
    alu_out = alu_in1 + alu_in2;
    if (alu_src) begin
      case (alu_in3)
        2'b00:   alu_out = alu_in1;
        2'b01:   alu_out = alu_in1 + 8'd1;
        2'b10:   alu_out = alu_in1 - 8'd2;
        default: alu_out = alu_in1 - 8'd1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (prev_addr == 8'hFF && imem_addr == 8'h00) wrap_cnt <= wrap_cnt + 1;
    prev_addr <= imem_addr;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
  endtask

  task automatic load(input logic [7:0] fill, input logic [7:0] p[$]);
    for (int i = 0; i < 256; i++) mem[i] = fill;
    for (int i = 0; i < p.size(); i++) mem[i] = p[i];
  endtask

  task automatic check_regs(input string tag, input logic [3:0][7:0] want);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      check($sformatf("%s.r%0d", tag, i), dbg_data, want[i]);
    end
    dbg_sel = 2'd0;
  endtask

  // Instruction-level reference: executes the program in mem from PC 0 on the shadow registers.
  task automatic model_run(output exp_t e);
    logic [7:0] pc, ins;
    logic [7:0] r [4];
    logic [1:0] rs, rt;
    int steps;
    pc = 8'd0;
    steps = 0;
    e.err = 1'b0;
    e.edges = -1;
    for (int i = 0; i < 4; i++) r[i] = m_regs[i];
    while (steps < 5000) begin
      ins = mem[pc];
      rs = ins[5:4];
      rt = ins[3:2];
      steps++;
      if (ins[7:6] == 2'b11) begin
        e.edges = 3 * steps;
        break;
      end
      case (ins[7:6])
        2'b00: begin r[rt] = r[rs] + r[rt]; pc = pc + 8'd1; end
        2'b01: begin
          case (ins[1:0])
            2'b00:   r[rt] = r[rs];
            2'b01:   r[rt] = r[rs] + 8'd1;
            2'b10:   r[rt] = r[rs] - 8'd2;
            default: r[rt] = r[rs] - 8'd1;
          endcase
          pc = pc + 8'd1;
        end
        default: pc = (r[rs] == 8'd0) ? pc + 8'd1 + {{4{ins[3]}}, ins[3:0]} : pc + 8'd1;
      endcase
`ifdef ALU_SEQ_WATCHDOG_EN
      if (steps == WD_STEPS) begin
        e.err = 1'b1;
        e.edges = 3 * steps;
        break;
      end
`endif
    end
    for (int i = 0; i < 4; i++) begin
      e.regs[i] = r[i];
      m_regs[i] = r[i];
    end
  endtask

  task automatic run_prog(input string tag);
    exp_t e, x;
    int edges, busy_gaps;
    logic [7:0] last_r0;
    bit got_done;
    model_run(e);
    sb.push_back(e);
    r0_trace.delete();
    alu_seen = 1'b0;
    dbg_sel = 2'd0;
    @(negedge clk);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, ".busy_up"}, busy, 1);
    check({tag, ".fetch_addr"}, imem_addr, 0);
    last_r0 = dbg_data;
    edges = 0;
    busy_gaps = 0;
    got_done = 1'b0;
    while (edges < 3000 && !got_done) begin
      step();
      edges++;
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (!busy) busy_gaps++;
        if (dbg_data != last_r0) begin
          r0_trace.push_back(dbg_data);
          last_r0 = dbg_data;
        end
        if (alu_src && !alu_seen) begin
          alu_seen = 1'b1;
          cap_in1 = alu_in1;
          cap_in3 = alu_in3;
        end
      end
    end
    check({tag, ".done_seen"}, got_done, 1);
    x = sb.pop_front();
    check({tag, ".latency"}, edges, x.edges);
    check({tag, ".err"}, err, x.err);
    check({tag, ".busy_fall"}, busy, 0);
    check({tag, ".busy_gaps"}, busy_gaps, 0);
    $display("RUN %s edges=%0d err=%0b busy=%0b", tag, edges, err, busy);
    check_regs(tag, x.regs);
    step();
    check({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    int busy_low, done_cnt, wrap_before;
    rst = 1'b1;
    start = 1'b0;
    dbg_sel = 2'd0;
    load(8'h00, '{8'hC0});
    do_reset();

    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.err", err, 0);
    check("reset.imem_addr", imem_addr, 0);
    check("reset.alu", {alu_src, alu_in1, alu_in2, alu_in3}, 0);
    check_regs("reset", '0);

    load(8'h00, '{8'h41, 8'h41, 8'h00, 8'hC0});
    run_prog("progA");
    check("progA.trace_len", r0_trace.size(), 3);
    if (r0_trace.size() >= 3) begin
      check("progA.trace0", r0_trace[0], 8'h01);
      check("progA.trace1", r0_trace[1], 8'h02);
      check("progA.trace2", r0_trace[2], 8'h04);
    end

    do_reset();
    load(8'h00, '{8'h56, 8'hC0});
    run_prog("unary_sub2");
    check("unary_sub2.alu_seen", alu_seen, 1);
    check("unary_sub2.alu_in1", cap_in1, 8'h00);
    check("unary_sub2.alu_in3", cap_in3, 2'b10);

    do_reset();
    load(8'h00, '{8'hA1, 8'h41, 8'h41, 8'hC0});
    run_prog("beqz_taken");
    load(8'h00, '{8'h69, 8'hC0});
    run_prog("preload_r2");
    load(8'h00, '{8'hA1, 8'h41, 8'h41, 8'hC0});
    run_prog("beqz_not_taken");

    do_reset();
    load(8'h00, '{8'hAF});
`ifdef ALU_SEQ_WATCHDOG_EN
    run_prog("watchdog");
`else
    @(negedge clk);
    start = 1'b1;
    step();
    start = 1'b0;
    busy_low = 0;
    done_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!busy) busy_low++;
      if (done) done_cnt++;
      step();
    end
    $display("RUN self_loop cycles=1000 busy_low=%0d done=%0d", busy_low, done_cnt);
    check("self_loop.busy_low", busy_low, 0);
    check("self_loop.done", done_cnt, 0);
`endif

    do_reset();
    load(8'h00, '{8'h41, 8'h41, 8'h00, 8'hC0});
    dbg_sel = 2'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart.start_ignored", imem_addr, 8'h01);
    check("restart.r0_written", dbg_data, 8'h01);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
    check("restart.busy", busy, 0);
    check("restart.done", done, 0);
    check("restart.err", err, 0);
    check("restart.imem_addr", imem_addr, 0);
    check("restart.alu", {alu_src, alu_in1, alu_in2, alu_in3}, 0);
    check_regs("restart", '0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) done_cnt++;
    end
    $display("RUN reset_abort idle_cycles=20 done=%0d", done_cnt);
    check("restart.no_done", done_cnt, 0);
    run_prog("restart.run");

    do_reset();
    load(8'h41, '{8'h83, 8'h41, 8'hC0});
    wrap_before = wrap_cnt;
    run_prog("pc_wrap");
`ifndef ALU_SEQ_WATCHDOG_EN
    check("pc_wrap.ff_to_00", wrap_cnt - wrap_before, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control unit that fetches 8-bit instructions from a synchronous instruction memory, decodes them, and sequences the shared 8-bit ALU through its two modes (two-operand add; unary pass/+1/−2/−1). It owns a 4×8 register file and the program counter, writes ALU results back, and resolves a zero-test branch. It sits between the instruction ROM and the ALU and is started and observed through a START/BUSY/DONE handshake.

## Interface
- MAX_STEPS, 255: instruction budget per run for the watchdog (used only when the watchdog is compiled in).
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  run request; sampled only in IDLE.
- BUSY  out  1  high from the cycle after START is accepted until the run ends.
- DONE  out  1  one-cycle pulse when a run ends.
- ERR  out  1  qualifies DONE: 1 means watchdog abort; otherwise 0.
- IMEM_ADDR  out  8  instruction address (registered PC).
- IMEM_DATA  in  8  instruction, valid one cycle after IMEM_ADDR.
- ALU_SRC  out  1  0 = IN1+IN2, 1 = unary op selected by ALU_IN3.
- ALU_IN1  out  8  first operand, R[RS].
- ALU_IN2  out  8  second operand, R[RT].
- ALU_IN3  out  2  unary select: 00 pass, 01 +1, 10 −2, 11 −1.
- ALU_OUT  in  8  combinational ALU result.
- DBG_SEL  in  2  debug register select.
- DBG_DATA  out  8  R[DBG_SEL], combinational.

## Operation
- Instruction fields: OP[7:6], RS[5:4], RT[3:2], FN[1:0].
- OP 00 ADD: R[RT] ← R[RS] + R[RT] mod 256 (ALU_SRC=0).
- OP 01 UNARY: R[RT] ← f(R[RS]), ALU_SRC=1, ALU_IN3=FN; mod-256 wrap.
- OP 10 BEQZ: if R[RS]==0, PC ← PC+1+sext({RT,FN}) mod 256; else PC ← PC+1. No register write. ALU outputs held at 0.
- OP 11 HALT: end the run normally (DONE=1, ERR=0).
- States:
  - IDLE: START → FETCH; PC←0; BUSY←1.
  - FETCH: IMEM_ADDR=PC → DECODE.
  - DECODE: IR←IMEM_DATA → EXEC.
  - EXEC:
    - ADD/UNARY: capture ALU_OUT into R[RT], PC←PC+1.
    - BEQZ: update PC.
    - Non-HALT → FETCH.
    - HALT → IDLE, with BUSY←0 and DONE←1 for one cycle.
- The PC is 8 bits and wraps from 255 to 0. There is no fault on wrap.
- START outside IDLE is ignored. START held high in IDLE starts a run.
- Registers are retained across runs. Only RST clears them.
- Reset, including mid-run, sets the following: state IDLE, PC 0, IR 0, R0–R3 0, BUSY 0, DONE 0, ERR 0, IMEM_ADDR 0, ALU_SRC/ALU_IN1/ALU_IN2/ALU_IN3 0. No DONE is produced for an aborted run.

## Timing
- Every instruction takes exactly 3 cycles (FETCH, DECODE, EXEC).
- ALU inputs are driven only in EXEC of ADD/UNARY. They are 0 in all other states.
- Writeback occurs on the edge that ends EXEC. A following instruction reading the same register sees the new value.
- START is accepted on edge k. The first FETCH is in cycle k+1.
- A program of N instructions ending in HALT asserts DONE in cycle k+1+3N, for exactly one cycle. BUSY falls in that same cycle.
- DBG_DATA has zero latency and reflects the write one cycle after the write edge.

## Configuration
- ALU_SEQ_WATCHDOG_EN defined:
  - An 8-bit step counter is cleared on START and increments at each EXEC.
  - When it reaches MAX_STEPS on a non-HALT EXEC, the block goes to IDLE with DONE=1 and ERR=1 for one cycle.
  - Register writeback for that final instruction still occurs.
- ALU_SEQ_WATCHDOG_EN undefined: no counter, ERR is tied 0, and runs only end on HALT or RST.

## Structure
- Package alu_seq_pkg holds:
  - opcode constants (OP_ADD, OP_UNARY, OP_BEQZ, OP_HALT);
  - unary select constants;
  - field bit positions;
  - the state enum (IDLE, FETCH, DECODE, EXEC).
- Sub-module alu_seq_regfile is the 4×8 register file:
  - two combinational read ports (RS, RT) plus the debug read port;
  - one synchronous write port;
  - synchronous clear on RST.

## Test plan
- Program 0x41,0x41,0x00,0xC0, START → R0 steps 1,2,4. DONE pulses once 13 cycles after the START edge, with ERR=0. BUSY is high for cycles 1–12.
- Program 0x56,0xC0 from reset → R1=0xFE. During EXEC: ALU_SRC=1, ALU_IN3=10, ALU_IN1=0x00.
- Program 0xA1,0x41,0x41,0xC0 (R2=0, BEQZ +1) → second instruction skipped, R0=1. With R2≠0 preloaded via 0x69, not taken.
- Program 0xAF (BEQZ −1 self-loop):
  - with ALU_SEQ_WATCHDOG_EN and MAX_STEPS=10, DONE and ERR are both 1 after 10 EXECs;
  - without the macro, BUSY stays 1 for 1000 cycles.
- START pulsed during EXEC and RST asserted mid-DECODE:
  - START is ignored;
  - after RST, all outputs and DBG_DATA for R0–R3 read 0, and no DONE is produced;
  - a subsequent START fetches from address 0.
- Memory with 0x41 everywhere except HALT at address 2 reached only via wrap: execution from 0 runs through 255, wraps to 0, and IMEM_ADDR shows 0xFF followed by 0x00.
